// File: rtl/regfile_scoreboard_if.sv
// Register file bus: read ports, writeback, issue and scoreboard status.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic [NREGS-1:0]      busy_vec;
  logic [AW:0]           busy_cnt;
  logic                  wb_unexpected;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec, busy_cnt, wb_unexpected
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec, busy_cnt, wb_unexpected
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-first bypass, hardwired r0 and a
// per-register busy scoreboard with outstanding-count tracking.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy_q;
  logic [NREGS-1:0]           busy_nxt;
  logic [AW:0]                cnt_q;
  logic [AW:0]                cnt_nxt;
  logic                       unexp_q;
  logic                       unexp_nxt;

  logic                       wr_live;
  logic                       iss_live;
  logic                       cnt_inc;
  logic                       cnt_dec;

  logic [NREAD*XLEN-1:0]      rd_data_c;
  logic [NREAD-1:0]           rd_busy_c;
  logic [AW-1:0]              ra;

  assign wr_live  = bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_live = bus.iss_en && (bus.iss_addr != '0);

  // Combinational read ports: r0 reads zero, a same-cycle writeback bypasses storage
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (ra == '0) begin
        rd_data_c[i*XLEN +: XLEN] = '0;
        rd_busy_c[i]              = 1'b0;
      end else if (bus.wr_en && (bus.wr_addr == ra)) begin
        rd_data_c[i*XLEN +: XLEN] = bus.wr_data;
        rd_busy_c[i]              = 1'b0;
      end else begin
        rd_data_c[i*XLEN +: XLEN] = regs[ra];
        rd_busy_c[i]              = busy_q[ra];
      end
    end
  end

  // Next scoreboard state: clear on retire, then set on issue so a same-address issue wins
  always_comb begin
    busy_nxt = busy_q;
    if (wr_live)  busy_nxt[bus.wr_addr]  = 1'b0;
    if (iss_live) busy_nxt[bus.iss_addr] = 1'b1;

    cnt_inc   = iss_live && !busy_q[bus.iss_addr];
    cnt_dec   = wr_live && busy_q[bus.wr_addr] &&
                !(iss_live && (bus.iss_addr == bus.wr_addr));
    unique case ({cnt_inc, cnt_dec})
      2'b10:   cnt_nxt = cnt_q + 1'b1;
      2'b01:   cnt_nxt = cnt_q - 1'b1;
      default: cnt_nxt = cnt_q;
    endcase

    unexp_nxt = wr_live && !busy_q[bus.wr_addr];
  end

  // Register storage: synchronous clear, r0 never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_live) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard state and the unexpected-writeback pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      unexp_q <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      cnt_q   <= cnt_nxt;
      unexp_q <= unexp_nxt;
    end
  end

  assign bus.rd_data       = rd_data_c;
  assign bus.rd_busy       = rd_busy_c;
  assign bus.busy_vec      = busy_q;
  assign bus.busy_cnt      = cnt_q;
  assign bus.wb_unexpected = unexp_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 32x32 general-purpose register file.
- Adds N combinational read ports, write-first bypass, synchronous clear and a per-register busy scoreboard with outstanding-count tracking.
- Sits in decode/writeback of the pipelined RV32 core: decode reads operands and marks destinations pending; writeback retires them.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers; power of two, >=2; AW = $clog2(NREGS) derived locally
- NREAD, 2, number of independent read ports, >=1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- rd_addr  in  NREAD*AW  read address, port i at [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NREAD  1 = operand at port i not yet available
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  issue strobe: mark iss_addr pending
- iss_addr  in  AW  destination being issued
- busy_vec  out  NREGS  registered busy bit per register
- busy_cnt  out  AW+1  number of set bits in busy_vec
- wb_unexpected  out  1  registered 1-cycle pulse: writeback to a non-busy register

Behaviour:
- Reset: rst_n=0 at posedge clk clears all registers to 0, busy_vec=0, busy_cnt=0 and wb_unexpected=0. While rst_n=0, wr_en and iss_en are ignored. Reset mid-operation discards all pending state in that edge.
- Register 0 is hardwired:
  - reads return 0 and rd_busy=0;
  - writes, issues and its busy bit are ignored, and busy_vec[0] is always 0;
  - wr_en to address 0 never raises wb_unexpected.
- Write: wr_en && wr_addr!=0 stores wr_data at the next posedge (1-cycle latency to storage).
- Read (combinational, per port i):
  - addr==0: rd_data=0;
  - else if wr_en && wr_addr==addr: rd_data=wr_data (write-first bypass);
  - else: rd_data = stored value.
- rd_busy[i] = busy_vec[addr] & ~(wr_en && wr_addr==addr), and 0 when addr==0.
- Issue in the current cycle does not affect this cycle's rd_busy (busy_vec is registered).
- Busy update at posedge, nonzero addresses only:
  - iss_en sets busy[iss_addr];
  - wr_en clears busy[wr_addr];
  - same address on both in one cycle: set wins, busy stays 1 (retire old producer, claim for new).
- busy_cnt next value = current +1 if the issue sets a previously clear bit, -1 if the writeback clears a previously set bit (not overridden by a same-address issue), 0 net if both. Must always equal popcount(busy_vec).
- Re-issue of an already-busy register: bit stays 1, count unchanged.
- wb_unexpected next value = wr_en && wr_addr!=0 && !busy_vec[wr_addr]. The data is still written.
- No overflow is possible: the count is bounded by NREGS-1.

Test Plan:
- Reset then read all addresses on every port -> rd_data=0, rd_busy=0, busy_vec=0, busy_cnt=0.
- iss_en addr 5; next cycle read 5 -> rd_busy=1, busy_cnt=1. Then wr_en addr 5 data 0xDEADBEEF with port 1 reading 5 -> same cycle rd_data=0xDEADBEEF, rd_busy=0. Next cycle busy_cnt=0 and stored value 0xDEADBEEF.
- Same cycle iss_en addr 7 and wr_en addr 7 (7 busy beforehand) -> busy_vec[7]=1, busy_cnt unchanged, stored data updated.
- wr_en addr 0 data 0x1234 and iss_en addr 0 -> reads of 0 return 0, busy_vec[0]=0, wb_unexpected=0.
- wr_en addr 9 while not busy -> wb_unexpected=1 for exactly one cycle, register 9 updated.
- Issue regs 1..31, then assert rst_n=0 for one cycle with wr_en active -> all registers 0, busy_cnt=0, the write is discarded. Repeat with NREAD=4 and XLEN=64 for parameter coverage.
